// File: rtl/tdm_pkg.sv
// Shared types and default geometry for the TDM demultiplexer.
// The default lane count and width are picked up by tdm_demux.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int DEF_LANES = 8;
  localparam int DEF_W     = 4;

endpackage

// File: rtl/onehot_decoder.sv
// Binary-to-one-hot decoder with an enable.
// When the enable is low the output is all-zero.
module onehot_decoder #(
  parameter int N = 8
) (
  input  logic [$clog2(N)-1:0] i_bin,
  input  logic                 i_en,
  output logic [N-1:0]         o_onehot
);

  always_comb begin
    // NOTE: assign a default first so that every path drives the output and no latch is inferred.
    o_onehot = '0;
    if (i_en) o_onehot[i_bin] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM beats are collected into a staging frame, which is published atomically to lane_q.
// The framer hunts for sync and then tracks the slot position, recovering from framing violations.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int W     = DEF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       din,
  input  logic               din_vld,
  input  logic               sync,
  output logic [LANES*W-1:0] lane_q,
  output logic [LANES-1:0]   slot_onehot,
  output logic               frame_done,
  output logic               sync_err,
  output logic               locked
);

  localparam int              SW        = $clog2(LANES);
  localparam logic [SW-1:0]   LAST_SLOT = SW'(LANES - 1);

  state_t                   r_state, w_state_nxt;
  logic [SW-1:0]            r_slot, w_slot_nxt;
  logic [LANES-1:0][W-1:0]  r_staging, w_staging_nxt;
  logic [LANES-1:0][W-1:0]  r_lane_q;
  logic                     r_frame_done, w_frame_done_nxt;
  logic                     r_sync_err, w_sync_err_nxt;
  logic                     r_locked;

  always_comb begin
    w_state_nxt      = r_state;
    w_slot_nxt       = r_slot;
    w_staging_nxt    = r_staging;
    w_frame_done_nxt = 1'b0;
    w_sync_err_nxt   = 1'b0;
    if (din_vld) begin
      case (r_state)
        HUNT: begin
          if (sync) begin
            w_staging_nxt[0] = din;
            w_slot_nxt       = SW'(1);
            w_state_nxt      = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // A sync beat always starts a new frame; it is only an error when it cuts one short.
            w_staging_nxt[0] = din;
            w_slot_nxt       = SW'(1);
            w_sync_err_nxt   = (r_slot != '0);
          end else if (r_slot == '0) begin
            w_sync_err_nxt   = 1'b1;
            w_state_nxt      = HUNT;
          end else begin
            w_staging_nxt[r_slot] = din;
            if (r_slot == LAST_SLOT) begin
              w_slot_nxt       = '0;
              w_frame_done_nxt = 1'b1;
            end else begin
              w_slot_nxt = r_slot + SW'(1);
            end
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= HUNT;
      r_slot       <= '0;
      // NOTE: the staging frame is cleared on reset so that no stale lane can ever be published.
      r_staging    <= '0;
      r_lane_q     <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_slot       <= w_slot_nxt;
      r_staging    <= w_staging_nxt;
      if (w_frame_done_nxt) r_lane_q <= w_staging_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_sync_err   <= w_sync_err_nxt;
      r_locked     <= (w_state_nxt == LOCKED);
    end
  end

  onehot_decoder #(
    .N (LANES)
  ) u_slot_dec (
    .i_bin    (r_slot),
    .i_en     (r_locked),
    .o_onehot (slot_onehot)
  );

  assign lane_q     = r_lane_q;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign locked     = r_locked;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (LANES=8, W=4).
// Inputs change on the falling edge and outputs are sampled on the following falling edge.
module tb_tdm_demux;

  localparam int LANES = 8;
  localparam int W     = 4;
  localparam logic [7:0] EXP_OH [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [W-1:0]         din = '0;
  logic                 din_vld = 1'b0;
  logic                 sync = 1'b0;
  logic [LANES*W-1:0]   lane_q;
  logic [LANES-1:0]     slot_onehot;
  logic                 frame_done;
  logic                 sync_err;
  logic                 locked;

  int n_checks = 0;
  int n_errors = 0;

  tdm_demux #(.LANES(LANES), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_vld     (din_vld),
    .sync        (sync),
    .lane_q      (lane_q),
    .slot_onehot (slot_onehot),
    .frame_done  (frame_done),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  // The two pulses must never coincide.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (frame_done && sync_err) begin
        n_errors++;
        $display("FAIL pulse_overlap: frame_done=%0b sync_err=%0b required not both high", frame_done, sync_err);
      end
    end
  end

  // Drive one cycle of input, then wait to the next falling edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic s);
    din_vld = v;
    din     = d;
    sync    = s;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({lane_q, slot_onehot, frame_done, sync_err, locked} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: lane_q=%h onehot=%h done=%0b err=%0b locked=%0b required all 0",
               lane_q, slot_onehot, frame_done, sync_err, locked);
    end
    rst = 1'b0;
    step(1'b0, 4'h0, 1'b0);
    n_checks++;
    if ({frame_done, sync_err, locked, slot_onehot} !== '0) begin
      n_errors++;
      $display("FAIL reset_release: done=%0b err=%0b locked=%0b onehot=%h required all 0",
               frame_done, sync_err, locked, slot_onehot);
    end
  endtask

  task automatic test_single_frame();
    for (int k = 0; k < LANES; k++) begin
      step(1'b1, W'(k), k == 0);
      n_checks++;
      if (slot_onehot !== EXP_OH[k] || locked !== 1'b1) begin
        n_errors++;
        $display("FAIL single_slot%0d: onehot=%h locked=%0b required %h/1", k, slot_onehot, locked, EXP_OH[k]);
      end
      n_checks++;
      if (frame_done !== (k == LANES - 1)) begin
        n_errors++;
        $display("FAIL single_done%0d: got %0b required %0b", k, frame_done, k == LANES - 1);
      end
      if (k < LANES - 1) begin
        n_checks++;
        if (lane_q !== 32'h0) begin
          n_errors++;
          $display("FAIL single_partial%0d: lane_q=%h required 00000000", k, lane_q);
        end
      end
    end
    n_checks++;
    if (lane_q !== 32'h76543210) begin
      n_errors++;
      $display("FAIL single_lane_q: got %h required 76543210", lane_q);
    end
    step(1'b0, 4'h0, 1'b0);
    n_checks++;
    if (frame_done !== 1'b0 || lane_q !== 32'h76543210 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL single_after: done=%0b lane_q=%h locked=%0b required 0/76543210/1", frame_done, lane_q, locked);
    end
  endtask

  task automatic test_gapped_frame();
    for (int k = 0; k < LANES; k++) begin
      step(1'b1, W'(k), k == 0);
      n_checks++;
      if (slot_onehot !== EXP_OH[k] || frame_done !== (k == LANES - 1)) begin
        n_errors++;
        $display("FAIL gap_beat%0d: onehot=%h done=%0b required %h/%0b", k, slot_onehot, frame_done,
                 EXP_OH[k], k == LANES - 1);
      end
      step(1'b0, 4'hF, 1'b1);
      n_checks++;
      if (slot_onehot !== EXP_OH[k] || frame_done !== 1'b0) begin
        n_errors++;
        $display("FAIL gap_idle%0d: onehot=%h done=%0b required %h/0", k, slot_onehot, frame_done, EXP_OH[k]);
      end
    end
    n_checks++;
    if (lane_q !== 32'h76543210) begin
      n_errors++;
      $display("FAIL gap_lane_q: got %h required 76543210", lane_q);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first_at = -1;
    int second_at = -1;
    for (int k = 0; k < 2 * LANES; k++) begin
      step(1'b1, (k < LANES) ? W'(k) : W'(4'hF - W'(k - LANES)), (k % LANES) == 0);
      if (frame_done) begin
        pulses++;
        if (first_at < 0) first_at = k; else second_at = k;
      end
      if (k == LANES - 1) begin
        n_checks++;
        if (lane_q !== 32'h76543210) begin
          n_errors++;
          $display("FAIL b2b_first_lane_q: got %h required 76543210", lane_q);
        end
      end
    end
    n_checks++;
    if (pulses != 2 || second_at - first_at != 8) begin
      n_errors++;
      $display("FAIL b2b_pulses: count=%0d spacing=%0d required 2/8", pulses, second_at - first_at);
    end
    n_checks++;
    if (lane_q !== 32'h89ABCDEF) begin
      n_errors++;
      $display("FAIL b2b_lane_q: got %h required 89abcdef", lane_q);
    end
  endtask

  task automatic test_resync_mid_frame();
    step(1'b1, 4'h1, 1'b1);
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'hA, 1'b1);
    n_checks++;
    if (sync_err !== 1'b1 || frame_done !== 1'b0 || locked !== 1'b1 || slot_onehot !== 8'h02) begin
      n_errors++;
      $display("FAIL resync_err: err=%0b done=%0b locked=%0b onehot=%h required 1/0/1/02",
               sync_err, frame_done, locked, slot_onehot);
    end
    n_checks++;
    if (lane_q !== 32'h89ABCDEF) begin
      n_errors++;
      $display("FAIL resync_hold: lane_q=%h required 89abcdef", lane_q);
    end
    for (int k = 1; k < LANES; k++) begin
      step(1'b1, W'(k), 1'b0);
      n_checks++;
      if (sync_err !== 1'b0 || frame_done !== (k == LANES - 1)) begin
        n_errors++;
        $display("FAIL resync_beat%0d: err=%0b done=%0b required 0/%0b", k, sync_err, frame_done, k == LANES - 1);
      end
    end
    n_checks++;
    if (lane_q !== 32'h7654321A) begin
      n_errors++;
      $display("FAIL resync_lane_q: got %h required 7654321a", lane_q);
    end
  endtask

  task automatic test_missing_sync();
    step(1'b1, 4'h5, 1'b0);
    n_checks++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || slot_onehot !== 8'h00 || frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL nosync_err: err=%0b locked=%0b onehot=%h done=%0b required 1/0/00/0",
               sync_err, locked, slot_onehot, frame_done);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, W'(k + 6), 1'b0);
      n_checks++;
      if (sync_err !== 1'b0 || locked !== 1'b0 || slot_onehot !== 8'h00 || lane_q !== 32'h7654321A) begin
        n_errors++;
        $display("FAIL nosync_hunt%0d: err=%0b locked=%0b onehot=%h lane_q=%h required 0/0/00/7654321a",
                 k, sync_err, locked, slot_onehot, lane_q);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    step(1'b1, 4'h9, 1'b1);
    n_checks++;
    if (locked !== 1'b1 || slot_onehot !== 8'h02) begin
      n_errors++;
      $display("FAIL rstmid_relock: locked=%0b onehot=%h required 1/02", locked, slot_onehot);
    end
    for (int k = 1; k < 5; k++) step(1'b1, 4'h9, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({lane_q, slot_onehot, frame_done, sync_err, locked} !== '0) begin
      n_errors++;
      $display("FAIL rstmid_async: lane_q=%h onehot=%h done=%0b err=%0b locked=%0b required all 0",
               lane_q, slot_onehot, frame_done, sync_err, locked);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 4'h4, 1'b0);
    n_checks++;
    if ({frame_done, sync_err, locked, slot_onehot} !== '0) begin
      n_errors++;
      $display("FAIL rstmid_release: done=%0b err=%0b locked=%0b onehot=%h required all 0",
               frame_done, sync_err, locked, slot_onehot);
    end
    for (int k = 0; k < LANES; k++) begin
      step(1'b1, W'(k + 8), k == 0);
      n_checks++;
      if (frame_done !== (k == LANES - 1) || lane_q !== ((k == LANES - 1) ? 32'hFEDCBA98 : 32'h0)) begin
        n_errors++;
        $display("FAIL rstmid_frame%0d: done=%0b lane_q=%h", k, frame_done, lane_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gapped_frame();
    test_back_to_back();
    test_resync_mid_frame();
    test_missing_sync();
    test_reset_mid_frame();
    step(1'b0, 4'h0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter LANES, default 8; number of time slots (lanes) per frame, at least 2.
REQ-002 Parameter W, default 4; data width per slot.
REQ-003 Port clk, input, 1; clock, all state rising-edge.
REQ-004 Port rst, input, 1; reset, asynchronous, active-high.
REQ-005 Port din, input, W; serial TDM data beat.
REQ-006 Port din_vld, input, 1; din carries a valid beat this cycle.
REQ-007 Port sync, input, 1; marks the beat as slot 0; qualified by din_vld.
REQ-008 Port lane_q, output, LANES x W (packed, lane 0 LSBs); last complete frame, one W field per lane.
REQ-009 Port slot_onehot, output, LANES; one-hot slot expected for the next valid beat; all-zero when not locked.
REQ-010 Port frame_done, output, 1; one-cycle pulse when lane_q updates.
REQ-011 Port sync_err, output, 1; one-cycle pulse on a framing violation.
REQ-012 Port locked, output, 1; high while in state LOCKED.

Function
REQ-013 The FSM SHALL have two states, HUNT and LOCKED, with a slot counter of width $clog2(LANES).
REQ-014 In HUNT, beats without sync SHALL be discarded.
REQ-015 In HUNT, din_vld&&sync SHALL write din to staging slot 0, set slot=1, and enter LOCKED.
REQ-016 In LOCKED, each din_vld beat SHALL write din to staging[slot] and increment slot.
REQ-017 Cycles with din_vld=0 SHALL change no state (gaps allowed anywhere).
REQ-018 At slot LANES-1, the counter SHALL wrap to 0 (non-power-of-2 LANES included).
REQ-019 When the beat for slot LANES-1 is accepted, the next cycle SHALL copy staging (including that beat) to lane_q atomically and pulse frame_done; latency is 1 cycle.
REQ-020 lane_q SHALL otherwise hold; partial frames SHALL never be visible.
REQ-021 In LOCKED at slot 0, a beat with sync=1 SHALL be accepted normally, so back-to-back frames need no idle cycle.
REQ-022 In LOCKED at slot 0, a beat without sync SHALL be discarded, pulse sync_err next cycle, and enter HUNT.
REQ-023 In LOCKED at slot != 0, a beat with sync=1 SHALL pulse sync_err next cycle, abandon the partial frame (no frame_done), write din to staging slot 0, set slot=1, and stay LOCKED.
REQ-024 frame_done and sync_err SHALL never both be high in the same cycle.
REQ-025 slot_onehot SHALL be decoded from the registered slot counter only, with no combinational path from inputs.
REQ-026 locked SHALL be a registered state decode.

Reset
REQ-027 Reset SHALL force HUNT, slot=0, staging=0, lane_q=0, slot_onehot=0, frame_done=0, sync_err=0 and locked=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first sync beat after release starts a new frame.
REQ-029 No output SHALL pulse in the first cycle after reset release.

Structure
REQ-030 Package tdm_pkg SHALL hold the state enum (HUNT, LOCKED) and default LANES and W constants.
REQ-031 The binary-to-one-hot slot decode SHALL be sub-module onehot_decoder (parameter N), instantiated once.
REQ-032 There SHALL be one always_ff for state, counter and registers, and one always_comb for next-state.

Verification (LANES=8, W=4)
REQ-033 Sync beat with value 0, then beats 1..7 on consecutive cycles -> lane_q=0x76543210 one cycle after beat 7, frame_done high for exactly 1 cycle, locked=1.
REQ-034 Same frame with din_vld low every other cycle -> same lane_q, frame_done 1 cycle after the last beat; slot_onehot steps 0x02..0x80 then 0x01.
REQ-035 Two back-to-back frames (0..7 then F..8) -> two frame_done pulses 8 cycles apart; final lane_q=0x89ABCDEF.
REQ-036 Sync re-asserted at slot 3 -> sync_err pulse, no frame_done, that beat becomes lane 0 of the new frame; next full frame completes correctly.
REQ-037 Beat without sync at slot 0 while LOCKED -> sync_err pulse, locked=0, slot_onehot=0; subsequent non-sync beats are ignored.
REQ-038 rst asserted after 5 beats -> all outputs 0 immediately; after release a full frame completes with no stale data in lane_q.
